// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
//  Module      : serial_divider
//  Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//                Retires one quotient bit per clock through a single 33-bit
//                subtractor. Divide-by-zero and signed overflow complete
//                straight from IDLE with their architectural results.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] data1_in,
    input  logic [XLEN-1:0] data2_in,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter value on the final CALC cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   quo;       // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]   rem;       // partial remainder
    logic [XLEN-1:0]   div_mag;   // divisor magnitude
    logic              rem_sel;   // 1: return remainder, 0: return quotient
    logic              q_neg;     // quotient must be negated in FIX
    logic              r_neg;     // remainder must be negated in FIX

    // Request decode, only meaningful while IDLE
    logic              req_signed;
    logic              req_rem;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [XLEN-1:0]   dvd_mag;
    logic [XLEN-1:0]   dvs_mag;
    logic              div_zero;
    logic              overflow;
    logic              special;
    logic [XLEN-1:0]   special_result;

    // Iteration datapath
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic              take;

    // Sign fix-up
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_result;

    // Decode the incoming request: signedness, magnitudes and architectural special cases
    always_comb begin
        req_signed = ~op_i[0];
        req_rem    = op_i[1];
        dvd_neg    = req_signed & data1_in[XLEN-1];
        dvs_neg    = req_signed & data2_in[XLEN-1];
        dvd_mag    = dvd_neg ? (~data1_in + 1'b1) : data1_in;
        dvs_mag    = dvs_neg ? (~data2_in + 1'b1) : data2_in;
        div_zero   = (data2_in == '0);
        overflow   = req_signed && (data1_in == MIN_NEG) && (data2_in == ALL_ONES);
        special    = div_zero | overflow;
        if (div_zero) begin
            special_result = req_rem ? data1_in : ALL_ONES;
        end else begin
            special_result = req_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        rem_shift = {rem, quo[XLEN-1]};
        diff      = rem_shift - {1'b0, div_mag};
        take      = ~diff[XLEN];
    end

    // Two's-complement correction of the unsigned result
    always_comb begin
        quo_fixed  = q_neg ? (~quo + 1'b1) : quo;
        rem_fixed  = r_neg ? (~rem + 1'b1) : rem;
        fix_result = rem_sel ? rem_fixed : quo_fixed;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_nxt = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (count == CNT_LAST) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy_o    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            div_mag <= '0;
            rem_sel <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        count   <= '0;
                        quo     <= dvd_mag;
                        rem     <= '0;
                        div_mag <= dvs_mag;
                        rem_sel <= req_rem;
                        q_neg   <= dvd_neg ^ dvs_neg;
                        r_neg   <= dvd_neg;
                        if (special) begin
                            data_o <= special_result;
                        end
                    end
                end
                S_CALC: begin
                    quo   <= {quo[XLEN-2:0], take};
                    rem   <= take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    count <= count + CNT_W'(1);
                end
                S_FIX: begin
                    data_o <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_divider
//  Description : Self-checking bench for serial_divider. A cycle-level
//                reference tracks accept/latency/result from arithmetic and
//                is compared against the DUT every cycle; directed cases pin
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_s;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_divider #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .op_i     (op_s),
        .data1_in (d1),
        .data2_in (d2),
        .ready_o  (ready),
        .busy_o   (busy),
        .done_o   (done),
        .data_o   (dout)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: busy flag, cycles left until the done cycle, result register
    bit          m_busy;
    int          m_left;
    logic [31:0] m_data;
    logic [31:0] m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_data <= 32'd0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_pend <= ref_div(op_s, d1, d2);
                if (is_special(op_s, d1, d2)) begin
                    m_left <= 0;
                    m_data <= ref_div(op_s, d1, d2);
                end else begin
                    m_left <= 33;
                end
            end
        end else if (m_left == 0) begin
            m_busy <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) m_data <= m_pend;
        end
    end

    // Compare DUT against the reference every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check({31'd0, ready}, {31'd0, !m_busy}, "ready");
            check({31'd0, busy},  {31'd0, m_busy}, "busy");
            check({31'd0, done},  {31'd0, (m_busy && m_left == 0)}, "done");
            check(dout, m_data, "data");
        end
    end

    // Called in cycle 1 (just after the acceptance edge); waits for done_o
    task automatic wait_done(input logic [31:0] expv, input int lat, input string nm);
        int  c;
        bit  seen;
        c    = 1;
        seen = 1'b0;
        while (!seen && c <= 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else c++;
        end
        if (!seen) begin
            check(32'd0, 32'd1, {nm, "_timeout"});
        end else begin
            check(32'(c), 32'(lat), {nm, "_latency"});
            check(dout, expv, {nm, "_result"});
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int lat, input string nm);
        @(posedge clk); #1;
        start = 1'b1; op_s = op; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0; op_s = 2'($urandom); d1 = $urandom; d2 = $urandom;
        wait_done(expv, lat, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; start = 1'b0; op_s = 2'b00; d1 = 32'd0; d2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check({31'd0, ready}, 32'd1, "reset_ready");
        check({31'd0, busy},  32'd0, "reset_busy");
        check(dout, 32'd0, "reset_data");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unsigned and signed normal path
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2,  34, "remu_100_7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");

        // Special cases complete in cycle 1
        run_op(2'b01, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(2'b10, 32'd12345, 32'd0, 32'd12345, 1, "rem_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_no_ovf");

        // start held high with changing operands for the whole operation
        @(posedge clk); #1;
        start = 1'b1; op_s = 2'b01; d1 = 32'd100; d2 = 32'd7;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            op_s = 2'($urandom); d1 = $urandom; d2 = $urandom;
            @(negedge clk);
            check({31'd0, ready}, 32'd0, "hold_ready_low");
            if (c == 34) begin
                check({31'd0, done}, 32'd1, "hold_done_c34");
                check(dout, 32'd14, "hold_result");
            end
        end
        @(posedge clk); #1;
        op_s = 2'b01; d1 = 32'd50; d2 = 32'd5;
        @(negedge clk);
        check({31'd0, ready}, 32'd1, "hold_ready_c35");
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(32'd10, 34, "hold_next");

        // Reset in cycle 10 abandons the operation
        @(posedge clk); #1;
        start = 1'b1; op_s = 2'b01; d1 = 32'hFFFF_FFFF; d2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({31'd0, ready}, 32'd1, "abort_ready");
        check({31'd0, busy},  32'd0, "abort_busy");
        check(dout, 32'd0, "abort_data");
        repeat (30) @(posedge clk);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");

        // Random sweep, biased toward small divisors and the special pairs
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 16));
                3:       rb = ~32'($urandom_range(0, 15));
                4:       begin rb = $urandom; ra = rb; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(rop, ra, rb, ref_div(rop, ra, rb), is_special(rop, ra, rb) ? 1 : 34, "sweep");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
